// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI target-side shift engine.
// Synchronizes SCK/NSS/MOSI into clk_i, detects SCK edges digitally and
// shifts 8/16/24/32-bit words with selectable CPOL/CPHA and bit order.
// A one-entry TX holding register feeds the shifter and a one-entry RX
// holding register presents received words.
// Optional feature macro: SPI_SLAVE_ERR_EN adds err_clr_i, ovr_o, udr_o
// (sticky overrun/underrun flags).
`ifndef SPI_DATA_WIDTH
`define SPI_DATA_WIDTH 32
`endif

module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       lsb_i,
  input  logic                       cpol_i,
  input  logic                       cpha_i,
  input  logic [1:0]                 dtb_i,
  output logic                       busy_o,
  input  logic                       tx_valid_i,
  output logic                       tx_ready_o,
  input  logic [`SPI_DATA_WIDTH-1:0] tx_data_i,
  output logic                       rx_valid_o,
  input  logic                       rx_ready_i,
  output logic [`SPI_DATA_WIDTH-1:0] rx_data_o,
  input  logic                       spi_sck_i,
  input  logic                       spi_nss_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o
`ifdef SPI_SLAVE_ERR_EN
  ,
  input  logic                       err_clr_i,
  output logic                       ovr_o,
  output logic                       udr_o
`endif
);

  localparam int W = `SPI_DATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  // word length in bits from the dtb code: 8, 16, 24, 32
  function automatic logic [5:0] nbits_of(input logic [1:0] dtb);
    nbits_of = {1'b0, dtb, 3'b000} + 6'd8;
  endfunction

  // bit presented on MISO for a right-aligned word of n bits
  function automatic logic out_bit(input logic [W-1:0] v, input logic lsb,
                                   input logic [5:0] n);
    logic [4:0] idx;
    idx = 5'(n - 6'd1);
    out_bit = lsb ? v[0] : v[idx];
  endfunction

  // insert one received bit; LSB-first enters at bit n-1 and moves right
  function automatic logic [W-1:0] rx_insert(input logic [W-1:0] v, input logic b,
                                             input logic lsb, input logic [5:0] n);
    logic [W-1:0] t;
    logic [4:0]   idx;
    idx = 5'(n - 6'd1);
    if (lsb) begin
      t      = v >> 1;
      t[idx] = b;
    end else begin
      t = {v[W-2:0], b};
    end
    rx_insert = t;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
  logic sck_prev_q, nss_prev_q, mosi_q;
  logic sck_rise_q, sck_fall_q, nss_fall_q, nss_rise_q;

  state_e         state_q, state_d;
  logic           tx_full_q, tx_full_d;
  logic [W-1:0]   tx_hold_q, tx_hold_d;
  logic [W-1:0]   tx_sh_q, tx_sh_d;
  logic [W-1:0]   rx_sh_q, rx_sh_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [5:0]     nbits_q, nbits_d;
  logic           lsb_q, lsb_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic           sampled_q, sampled_d;
  logic           miso_q, miso_d;
  logic           rx_valid_q, rx_valid_d;
  logic [W-1:0]   rx_data_q, rx_data_d;

  logic           load, push, lead, trail, samp, shft, tx_write;
  logic [W-1:0]   rx_word, load_word, tx_shifted;
  logic [5:0]     load_n;

  // pin synchronizers plus registered edge detection of SCK and NSS
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q  <= '0;
      nss_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      nss_prev_q  <= 1'b1;
      mosi_q      <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      nss_fall_q  <= 1'b0;
      nss_rise_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
      sck_rise_q  <= sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
      sck_fall_q  <= ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
      nss_fall_q  <= ~nss_sync_q[SYNC_STAGES-1] & nss_prev_q;
      nss_rise_q  <= nss_sync_q[SYNC_STAGES-1] & ~nss_prev_q;
    end
  end

  // next-state: frame FSM, word load/shift/sample, TX and RX holding registers
  always_comb begin
    state_d    = state_q;
    tx_full_d  = tx_full_q;
    tx_hold_d  = tx_hold_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    nbits_d    = nbits_q;
    lsb_d      = lsb_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sampled_d  = sampled_q;
    miso_d     = miso_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    load       = 1'b0;
    push       = 1'b0;
    load_n     = nbits_of(dtb_i);
    load_word  = tx_full_q ? tx_hold_q : '0;
    rx_word    = rx_insert(rx_sh_q, mosi_q, lsb_q, nbits_q);
    tx_shifted = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    lead       = cpol_q ? sck_fall_q : sck_rise_q;
    trail      = cpol_q ? sck_rise_q : sck_fall_q;
    samp       = cpha_q ? trail : lead;
    shft       = cpha_q ? lead : trail;
    tx_write   = tx_valid_i & ~tx_full_q;

    case (state_q)
      IDLE: begin
        if (nss_fall_q) begin
          state_d = XFER;
          load    = 1'b1;
        end
      end
      XFER: begin
        if (nss_rise_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
          tx_sh_d = '0;
          rx_sh_d = '0;
        end else if (samp) begin
          rx_sh_d   = rx_word;
          sampled_d = 1'b1;
          cnt_d     = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            push = 1'b1;
            load = 1'b1;
          end
        end else if (shft && sampled_q) begin
          // a shift edge before the word's first sample keeps the loaded bit
          tx_sh_d = tx_shifted;
          miso_d  = out_bit(tx_shifted, lsb_q, nbits_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      lsb_d     = lsb_i;
      cpol_d    = cpol_i;
      cpha_d    = cpha_i;
      nbits_d   = load_n;
      cnt_d     = load_n;
      tx_sh_d   = load_word;
      miso_d    = out_bit(load_word, lsb_i, load_n);
      rx_sh_d   = '0;
      sampled_d = 1'b0;
      tx_full_d = 1'b0;
    end
    if (tx_write) begin
      tx_full_d = 1'b1;
      tx_hold_d = tx_data_i;
    end

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (push && (!rx_valid_q || rx_ready_i)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_word;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      tx_full_q  <= 1'b0;
      tx_hold_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cnt_q      <= '0;
      nbits_q    <= 6'd8;
      lsb_q      <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sampled_q  <= 1'b0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_full_q  <= tx_full_d;
      tx_hold_q  <= tx_hold_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cnt_q      <= cnt_d;
      nbits_q    <= nbits_d;
      lsb_q      <= lsb_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sampled_q  <= sampled_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign busy_o     = (state_q == XFER);
  assign tx_ready_o = ~tx_full_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign spi_miso_o = miso_q;

`ifdef SPI_SLAVE_ERR_EN
  logic ovr_q, udr_q, ovr_set, udr_set;
  assign udr_set = load & ~tx_full_q;
  assign ovr_set = push & rx_valid_q & ~rx_ready_i;

  // sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_set | (ovr_q & ~err_clr_i);
      udr_q <= udr_set | (udr_q & ~err_clr_i);
    end
  end

  assign ovr_o = ovr_q;
  assign udr_o = udr_q;
`endif

endmodule
